// File: rtl/sprite_compositor_pipe.sv
// Resolves each scan pixel to a map/sprite object ID and image index, with per-frame collision report.
// Latency 2 cycles at 1 pixel/cycle; no backpressure, so every i_pix_valid beat emerges as o_valid two cycles later.
module sprite_compositor_pipe #(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_SIZE = 32,
  parameter int MAP_H       = 640,
  parameter int MAP_V       = 480,
  parameter int H_WIDTH     = 10,
  parameter int V_WIDTH     = 10,
  parameter int IDX_W       = H_WIDTH + V_WIDTH,
  parameter int ID_W        = $clog2(NUM_SPRITES + 1)
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst,
  input  logic                                      i_frame_start,
  input  logic [NUM_SPRITES*H_WIDTH-1:0]            i_sprite_x,
  input  logic [NUM_SPRITES*V_WIDTH-1:0]            i_sprite_y,
  input  logic [NUM_SPRITES-1:0]                    i_sprite_valid,
  input  logic                                      i_pix_valid,
  input  logic [H_WIDTH-1:0]                        i_VGA_H,
  input  logic [V_WIDTH-1:0]                        i_VGA_V,
  output logic [NUM_SPRITES*$clog2(SPRITE_SIZE)-1:0] o_mask_row_addr,
  input  logic [NUM_SPRITES*SPRITE_SIZE-1:0]        i_mask_row,
  output logic                                      o_valid,
  output logic [ID_W-1:0]                           o_object_id,
  output logic [IDX_W-1:0]                          o_pixel_index,
  output logic                                      o_collision,
  output logic [NUM_SPRITES-1:0]                    o_collision_mask
);

  localparam int SW = $clog2(SPRITE_SIZE);
  localparam logic [H_WIDTH-1:0] H_OFF  = H_WIDTH'((MAP_H - SPRITE_SIZE) / 2 + 1);
  localparam logic [V_WIDTH-1:0] V_OFF  = V_WIDTH'((MAP_V - SPRITE_SIZE) / 2 + 1);
  localparam logic [H_WIDTH-1:0] H_SPAN = H_WIDTH'(SPRITE_SIZE - 1);
  localparam logic [V_WIDTH-1:0] V_SPAN = V_WIDTH'(SPRITE_SIZE - 1);

  logic [NUM_SPRITES*H_WIDTH-1:0] act_x;
  logic [NUM_SPRITES*V_WIDTH-1:0] act_y;
  logic [NUM_SPRITES-1:0]         act_vld;

  logic [NUM_SPRITES-1:0][H_WIDTH-1:0] hmin, hmax, hdiff;
  logic [NUM_SPRITES-1:0][V_WIDTH-1:0] vmin, vmax, vdiff;
  logic [NUM_SPRITES-1:0]              hit_c;
  logic [IDX_W-1:0]                    map_idx_c;
  logic                                in_map_c;

  // Wrapped bounds give hmin > hmax, so the unsigned window test clips them naturally.
  always_comb begin
    for (int k = 0; k < NUM_SPRITES; k++) begin
      hmin[k]  = act_x[k*H_WIDTH +: H_WIDTH] + H_OFF;
      hmax[k]  = hmin[k] + H_SPAN;
      vmin[k]  = V_OFF - act_y[k*V_WIDTH +: V_WIDTH];
      vmax[k]  = vmin[k] + V_SPAN;
      hdiff[k] = i_VGA_H - hmin[k];
      vdiff[k] = i_VGA_V - vmin[k];
      hit_c[k] = act_vld[k] && (hmin[k] <= i_VGA_H) && (i_VGA_H <= hmax[k])
                            && (vmin[k] <= i_VGA_V) && (i_VGA_V <= vmax[k]);
      o_mask_row_addr[k*SW +: SW] = vdiff[k][SW-1:0];
    end
    map_idx_c = (IDX_W'(i_VGA_V) - IDX_W'(1)) * IDX_W'(MAP_H) + (IDX_W'(i_VGA_H) - IDX_W'(1));
    in_map_c  = (i_VGA_H >= H_WIDTH'(1)) && (i_VGA_H <= H_WIDTH'(MAP_H))
             && (i_VGA_V >= V_WIDTH'(1)) && (i_VGA_V <= V_WIDTH'(MAP_V));
  end

  logic                           s1_vld;
  logic [NUM_SPRITES-1:0]         s1_hit;
  logic [NUM_SPRITES-1:0][SW-1:0] s1_rel_h, s1_rel_v;
  logic [IDX_W-1:0]               s1_map_idx;
  logic                           s1_in_map;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      act_x      <= '0;
      act_y      <= '0;
      act_vld    <= '0;
      s1_vld     <= 1'b0;
      s1_hit     <= '0;
      s1_rel_h   <= '0;
      s1_rel_v   <= '0;
      s1_map_idx <= '0;
      s1_in_map  <= 1'b0;
    end else begin
      if (i_frame_start) begin
        act_x   <= i_sprite_x;
        act_y   <= i_sprite_y;
        act_vld <= i_sprite_valid;
      end
      s1_vld <= i_pix_valid;
      if (i_pix_valid) begin
        s1_hit     <= hit_c;
        s1_map_idx <= map_idx_c;
        s1_in_map  <= in_map_c;
        for (int k = 0; k < NUM_SPRITES; k++) begin
          s1_rel_h[k] <= hdiff[k][SW-1:0];
          s1_rel_v[k] <= vdiff[k][SW-1:0];
        end
      end
    end
  end

  logic [NUM_SPRITES-1:0][SPRITE_SIZE-1:0] rows;
  logic [NUM_SPRITES-1:0]                  opaque;
  logic [ID_W-1:0]                         win_id, opq_cnt;
  logic [IDX_W-1:0]                        win_idx;
  logic                                    coll_ev;

  // Walk from the lowest priority up so sprite 0 overrides everyone.
  always_comb begin
    rows    = i_mask_row;
    win_id  = '0;
    win_idx = s1_map_idx;
    opq_cnt = '0;
    opaque  = '0;
    for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
      opaque[k] = s1_hit[k] & rows[k][s1_rel_h[k]];
      opq_cnt   = opq_cnt + ID_W'(opaque[k]);
      if (opaque[k]) begin
        win_id  = ID_W'(k + 1);
        win_idx = IDX_W'({s1_rel_v[k], s1_rel_h[k]});
      end
    end
    if (!s1_in_map) begin
      win_id  = '0;
      win_idx = '0;
    end
    coll_ev = s1_vld && (opq_cnt >= ID_W'(2));
  end

  logic                   coll_acc;
  logic [NUM_SPRITES-1:0] coll_mask_acc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid          <= 1'b0;
      o_object_id      <= '0;
      o_pixel_index    <= '0;
      o_collision      <= 1'b0;
      o_collision_mask <= '0;
      coll_acc         <= 1'b0;
      coll_mask_acc    <= '0;
    end else begin
      o_valid <= s1_vld;
      if (s1_vld) begin
        o_object_id   <= win_id;
        o_pixel_index <= win_idx;
      end
      // An event landing on the frame pulse seeds the new frame's accumulator.
      if (i_frame_start) begin
        o_collision      <= coll_acc;
        o_collision_mask <= coll_mask_acc;
        coll_acc         <= coll_ev;
        coll_mask_acc    <= coll_ev ? opaque : '0;
      end else if (coll_ev) begin
        coll_acc      <= 1'b1;
        coll_mask_acc <= coll_mask_acc | opaque;
      end
    end
  end

endmodule

// File: tb/tb_sprite_compositor_pipe.sv
// Scoreboard bench: reference model pushes expected (ID, index, arrival cycle); a monitor pops on o_valid.
module tb_sprite_compositor_pipe;
  localparam int NS = 4, SZ = 32, HW = 10, VW = 10, IDXW = 20, IDW = 3, SW = 5;
  localparam int MAPH = 640, MAPV = 480;
  localparam int HOFF = (MAPH - SZ) / 2 + 1;
  localparam int VOFF = (MAPV - SZ) / 2 + 1;

  logic clk = 1'b0;
  logic rst;
  logic frame_start;
  logic [NS*HW-1:0] sprite_x;
  logic [NS*VW-1:0] sprite_y;
  logic [NS-1:0] sprite_valid;
  logic pix_valid;
  logic [HW-1:0] vga_h;
  logic [VW-1:0] vga_v;
  logic [NS*SW-1:0] mask_row_addr;
  logic [NS*SZ-1:0] mask_row = '0;
  logic o_valid;
  logic [IDW-1:0] object_id;
  logic [IDXW-1:0] pixel_index;
  logic collision;
  logic [NS-1:0] collision_mask;

  sprite_compositor_pipe dut (
    .i_clk(clk), .i_rst(rst), .i_frame_start(frame_start),
    .i_sprite_x(sprite_x), .i_sprite_y(sprite_y), .i_sprite_valid(sprite_valid),
    .i_pix_valid(pix_valid), .i_VGA_H(vga_h), .i_VGA_V(vga_v),
    .o_mask_row_addr(mask_row_addr), .i_mask_row(mask_row),
    .o_valid(o_valid), .o_object_id(object_id), .o_pixel_index(pixel_index),
    .o_collision(collision), .o_collision_mask(collision_mask)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [IDW-1:0]  id;
    logic [IDXW-1:0] idx;
    logic [31:0]     at;
  } exp_t;
  exp_t sbq[$];

  int total = 0, bad = 0;

  // Reference state: shadow/active sprite tables, mask images, collision accumulator.
  int sh_x[NS], sh_y[NS], act_x[NS], act_y[NS];
  bit sh_v[NS], act_v[NS];
  logic [SZ-1:0] rom[NS][SZ];
  bit acc;
  logic [NS-1:0] accm;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Mask ROM with one cycle of read latency.
  logic [NS*SW-1:0] addr_q;
  always @(posedge clk) addr_q <= mask_row_addr;
  always @(negedge clk)
    for (int k = 0; k < NS; k++) mask_row[k*SZ +: SZ] = rom[k][addr_q[k*SW +: SW]];

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (o_valid) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_valid: got o_valid=1 expected no output (cycle %0d)", cyc);
        end else begin
          e = sbq.pop_front();
          check("object_id", 32'(object_id), 32'(e.id));
          check("pixel_index", 32'(pixel_index), 32'(e.idx));
          check("latency_cycle", 32'(cyc), e.at);
        end
      end else if (sbq.size() > 0 && sbq[0].at <= 32'(cyc)) begin
        e = sbq.pop_front();
        check("missing_valid", 32'(o_valid), 32'd1);
      end
    end
  end

  function automatic void model_pixel(int h, int v);
    int hmin, vmin, id, idx, n;
    logic [NS-1:0] opq;
    exp_t e;
    id = 0; idx = 0; n = 0; opq = '0;
    for (int k = NS - 1; k >= 0; k--) begin
      hmin = act_x[k] + HOFF;
      vmin = VOFF - act_y[k];
      if (act_v[k] && hmin >= 0 && hmin + SZ - 1 < (1 << HW) && vmin >= 0 && vmin + SZ - 1 < (1 << VW)
          && h >= hmin && h < hmin + SZ && v >= vmin && v < vmin + SZ && rom[k][v - vmin][h - hmin]) begin
        opq[k] = 1'b1;
        n++;
        id = k + 1;
        idx = (v - vmin) * SZ + (h - hmin);
      end
    end
    if (id == 0) idx = (v - 1) * MAPH + (h - 1);
    if (!(h >= 1 && h <= MAPH && v >= 1 && v <= MAPV)) begin id = 0; idx = 0; end
    if (n >= 2) begin acc = 1'b1; accm = accm | opq; end
    e.id = IDW'(id); e.idx = IDXW'(idx); e.at = 32'(cyc + 2);
    sbq.push_back(e);
  endfunction

  task automatic drive_shadow();
    for (int k = 0; k < NS; k++) begin
      sprite_x[k*HW +: HW] = HW'(sh_x[k]);
      sprite_y[k*VW +: VW] = VW'(sh_y[k]);
      sprite_valid[k] = sh_v[k];
    end
  endtask

  task automatic pix(input int h, input int v);
    vga_h = HW'(h); vga_v = VW'(v); pix_valid = 1'b1;
    model_pixel(h, v);
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NS; k++) begin act_x[k] = 0; act_y[k] = 0; act_v[k] = 0; end
    acc = 0; accm = '0;
  endtask

  // Frame pulse after draining the pipe; optional pixel in the same cycle sees the old positions.
  task automatic frame(input bit with_pix, input int h, input int v);
    bit exp_c;
    logic [NS-1:0] exp_m;
    idle(3);
    drive_shadow();
    frame_start = 1'b1;
    exp_c = acc; exp_m = accm; acc = 0; accm = '0;
    if (with_pix) begin
      vga_h = HW'(h); vga_v = VW'(v); pix_valid = 1'b1;
      model_pixel(h, v);
    end
    for (int k = 0; k < NS; k++) begin act_x[k] = sh_x[k]; act_y[k] = sh_y[k]; act_v[k] = sh_v[k]; end
    @(negedge clk);
    frame_start = 1'b0; pix_valid = 1'b0;
    check("collision", 32'(collision), 32'(exp_c));
    check("collision_mask", 32'(collision_mask), 32'(exp_m));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected test end (cycle %0d)", cyc);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; vga_h = '0; vga_v = '0;
    for (int k = 0; k < NS; k++) begin
      sh_x[k] = 0; sh_y[k] = 0; sh_v[k] = 0;
      for (int r = 0; r < SZ; r++) rom[k][r] = '1;
    end
    drive_shadow();
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(o_valid), 0);
    check("reset_id", 32'(object_id), 0);
    check("reset_index", 32'(pixel_index), 0);
    check("reset_collision", 32'(collision), 0);
    check("reset_cmask", 32'(collision_mask), 0);
    rst = 1'b0;
    @(negedge clk);

    // Empty scene, first row
    for (int h = 1; h <= MAPH; h++) pix(h, 1);

    // One centred opaque sprite, corners and just outside
    sh_v[0] = 1; frame(0, 0, 0);
    pix(305, 225); pix(336, 256); pix(304, 225); pix(337, 256); pix(305, 224); pix(320, 240);

    // Two overlapping sprites: priority, then collision report and its clearing
    sh_v[1] = 1; frame(0, 0, 0);
    pix(310, 230); pix(320, 240); pix(336, 256);
    sh_x[1] = 100; frame(0, 0, 0);
    pix(320, 240); pix(410, 240);
    frame(0, 0, 0);

    // Transparent column 0
    sh_v[1] = 0; sh_x[1] = 0;
    for (int r = 0; r < SZ; r++) rom[0][r][0] = 1'b0;
    frame(0, 0, 0);
    pix(305, 230); pix(306, 230);
    for (int r = 0; r < SZ; r++) rom[0][r] = '1;

    // Shadow change without a pulse, then pulse with a pixel in the same cycle
    sh_x[0] = 50; drive_shadow();
    pix(305, 230); pix(336, 230);
    frame(1, 305, 231);
    pix(305, 231); pix(355, 231);

    // Sprite straddling the left edge never hits
    sh_x[0] = -320; sh_v[2] = 1; sh_x[2] = -330; sh_y[2] = 10;
    frame(0, 0, 0);
    for (int h = 1; h <= 20; h++) pix(h, 230);
    pix(1000 - 990, 215); pix(16, 240);

    // Reset mid-scan
    sh_x[0] = 0; sh_v[2] = 0; frame(0, 0, 0);
    vga_h = HW'(320); vga_v = VW'(240); pix_valid = 1'b1; model_pixel(320, 240);
    @(negedge clk);
    vga_h = HW'(321); model_pixel(321, 240);
    @(negedge clk);
    rst = 1'b1; pix_valid = 1'b0; sbq.delete(); model_reset();
    #1;
    check("midrst_valid", 32'(o_valid), 0);
    check("midrst_id", 32'(object_id), 0);
    check("midrst_index", 32'(pixel_index), 0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    pix(320, 240);
    idle(4);

    // Randomized frames
    for (int f = 0; f < 10; f++) begin
      for (int k = 0; k < NS; k++) begin
        sh_v[k] = ($urandom_range(0, 3) != 0);
        if (f % 2 == 0) begin
          sh_x[k] = int'($urandom_range(0, 120)) - 60;
          sh_y[k] = int'($urandom_range(0, 120)) - 60;
        end else begin
          sh_x[k] = int'($urandom_range(0, 660)) - 330;
          sh_y[k] = int'($urandom_range(0, 500)) - 250;
        end
        for (int r = 0; r < SZ; r++) rom[k][r] = $urandom;
      end
      frame($urandom_range(0, 1) == 1, int'($urandom_range(250, 400)), int'($urandom_range(180, 300)));
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 4) == 0) idle(1);
        if ($urandom_range(0, 7) == 0) pix(int'($urandom_range(1, 700)), int'($urandom_range(1, 500)));
        else pix(int'($urandom_range(240, 400)), int'($urandom_range(170, 310)));
      end
    end
    frame(0, 0, 0);

    idle(5);
    check("scoreboard_drained", 32'(sbq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
